// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding imem requests, closes the pc -> pc_next loop, queues {pc, instr} for decode.
// Response to dec_valid is 1 cycle; issue stalls while the queue is full, decode backpressures through dec_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pending_pc;
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic req_fire;
  logic push;
  logic pop;

  always_comb begin
    imem_req_addr  = pc & ~32'h3;
    imem_req_valid = !reset && (state == IDLE) && !redirect_valid && (count < CW'(QUEUE_DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    // A redirect kills the in-flight response, so it never lands in the queue.
    push           = !reset && (state == WAIT) && imem_rsp_valid && !redirect_valid;
    dec_valid      = !reset && (count != '0);
    pop            = dec_valid && dec_ready;
    dec_pc         = dec_valid ? q_pc[rd_ptr]    : 32'h0;
    dec_instr      = dec_valid ? q_instr[rd_ptr] : 32'h0;

    if (reset)
      pc_next = RESET_VECTOR;
    else if (redirect_valid)
      pc_next = redirect_pc & ~32'h3;
    else if (req_fire)
      pc_next = pc + 32'd4;
    else
      pc_next = pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pending_pc <= 32'h0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      unique case (state)
        WAIT:    state <= imem_rsp_valid ? IDLE : DROP;
        DROP:    state <= imem_rsp_valid ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: if (req_fire) begin
          pending_pc <= imem_req_addr;
          state      <= WAIT;
        end
        WAIT:    if (imem_rsp_valid) state <= IDLE;
        DROP:    if (imem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= pending_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an external PC register and a small instruction-memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .RESET_VECTOR (32'h0000_0100),
    .QUEUE_DEPTH  (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  always #5 clock = ~clock;

  // PC register with no enable.
  always @(posedge clock) pc <= pc_next;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'hE3A0_0001;
      32'h0000_0104: return 32'hE280_0001;
      default:       return addr ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory: responds rsp_delay cycles after an accepted request; man_vld injects a raw response.
  int          rsp_delay = 1;
  int          rsp_cnt   = 0;
  int          n_acc     = 0;
  logic [31:0] req_log [$];
  logic        auto_vld = 1'b0;
  logic [31:0] auto_dat = 32'h0;
  logic        man_vld  = 1'b0;
  logic [31:0] man_dat  = 32'h0;
  logic        acc;
  logic [31:0] acc_addr;

  assign imem_rsp_valid = auto_vld | man_vld;
  assign imem_rsp_data  = man_vld ? man_dat : auto_dat;

  always begin
    @(negedge clock);
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) begin
      n_acc++;
      req_log.push_back(acc_addr);
    end
    @(posedge clock);
    #1;
    if (rsp_cnt != 0) rsp_cnt--;
    if (acc) begin
      rsp_cnt  = rsp_delay;
      auto_dat = mem_word(acc_addr);
    end
    auto_vld = (rsp_cnt == 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic do_reset();
    tick();
    imem_req_ready = 1'b0;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int base;

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_pc_next", pc_next, 32'h100);
      check("rst_req_vld", 32'(imem_req_valid), 32'd0);
      check("rst_dec_vld", 32'(dec_valid), 32'd0);
      if (i == 0) begin
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
      end
      tick();
    end

    // Straight-line fetch
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    mid();
    check("sl_req_vld0", 32'(imem_req_valid), 32'd1);
    check("sl_req_addr0", imem_req_addr, 32'h100);
    check("sl_pc_next0", pc_next, 32'h104);
    tick(); mid();
    check("sl_wait_req_vld", 32'(imem_req_valid), 32'd0);
    check("sl_wait_pc_hold", pc_next, 32'h104);
    check("sl_wait_dec_vld", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("sl_dec_vld0", 32'(dec_valid), 32'd1);
    check("sl_dec_pc0", dec_pc, 32'h100);
    check("sl_dec_instr0", dec_instr, 32'hE3A0_0001);
    check("sl_req_addr1", imem_req_addr, 32'h104);
    check("sl_pc_next1", pc_next, 32'h108);
    tick(); mid();
    check("sl_dec_vld_gap", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("sl_dec_vld1", 32'(dec_valid), 32'd1);
    check("sl_dec_pc1", dec_pc, 32'h104);
    check("sl_dec_instr1", dec_instr, 32'hE280_0001);

    // Backpressure: queue fills, issue stops
    do_reset();
    base           = n_acc;
    dec_ready      = 1'b0;
    imem_req_ready = 1'b1;
    rsp_delay      = 1;
    repeat (8) tick();
    mid();
    check("bp_n_req", 32'(n_acc - base), 32'd2);
    check("bp_req_a0", req_log[base], 32'h100);
    check("bp_req_a1", req_log[base + 1], 32'h104);
    check("bp_req_vld", 32'(imem_req_valid), 32'd0);
    check("bp_pc_hold", pc_next, 32'h108);
    check("bp_dec_pc", dec_pc, 32'h100);
    check("bp_dec_instr", dec_instr, 32'hE3A0_0001);
    tick();
    dec_ready = 1'b1;
    mid();
    check("bp_full_req_vld", 32'(imem_req_valid), 32'd0);
    tick();
    dec_ready = 1'b0;
    mid();
    check("bp_req_vld2", 32'(imem_req_valid), 32'd1);
    check("bp_req_addr2", imem_req_addr, 32'h108);
    check("bp_pc_next2", pc_next, 32'h10C);
    repeat (3) tick();
    mid();
    check("bp_n_req2", 32'(n_acc - base), 32'd3);
    check("bp_req_a2", req_log[base + 2], 32'h108);
    check("bp_req_vld3", 32'(imem_req_valid), 32'd0);
    check("bp_pc_hold2", pc_next, 32'h10C);
    check("bp_dec_pc2", dec_pc, 32'h104);

    // Redirect with a full queue, decode popping, stray response in IDLE
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    dec_ready      = 1'b1;
    man_vld        = 1'b1;
    man_dat        = 32'hDEAD_BEEF;
    mid();
    check("rdf_pc_next", pc_next, 32'h3000);
    check("rdf_req_vld", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    man_vld        = 1'b0;
    imem_req_ready = 1'b0;
    mid();
    check("rdf_dec_vld", 32'(dec_valid), 32'd0);
    check("rdf_dec_pc", dec_pc, 32'h0);
    check("rdf_dec_instr", dec_instr, 32'h0);
    check("rdf_req_addr", imem_req_addr, 32'h3000);
    check("rdf_pc_hold", pc_next, 32'h3000);

    // Redirect in the same cycle as a WAIT response
    tick();
    imem_req_ready = 1'b1;
    mid();
    check("rdr_req_addr0", imem_req_addr, 32'h3000);
    check("rdr_pc_next0", pc_next, 32'h3004);
    tick(); mid();
    check("rdr_wait_dec_vld", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("rdr_dec_pc", dec_pc, 32'h3000);
    check("rdr_dec_instr", dec_instr, mem_word(32'h3000));
    check("rdr_req_addr1", imem_req_addr, 32'h3004);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4003;
    dec_ready      = 1'b1;
    mid();
    check("rdr_pc_next", pc_next, 32'h4000);
    check("rdr_req_vld", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    imem_req_ready = 1'b0;
    mid();
    check("rdr_dec_vld_after", 32'(dec_valid), 32'd0);
    check("rdr_idle_req_vld", 32'(imem_req_valid), 32'd1);
    check("rdr_idle_req_addr", imem_req_addr, 32'h4000);
    check("rdr_pc_hold", pc_next, 32'h4000);

    // Redirect while WAIT, response two cycles later
    do_reset();
    rsp_delay      = 2;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    mid();
    check("drop_req_addr0", imem_req_addr, 32'h100);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    mid();
    check("drop_pc_next", pc_next, 32'h2000);
    check("drop_req_vld_wait", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    mid();
    check("drop_req_vld", 32'(imem_req_valid), 32'd0);
    check("drop_dec_vld", 32'(dec_valid), 32'd0);
    check("drop_pc_hold", pc_next, 32'h2000);
    tick(); mid();
    check("drop_req_vld_idle", 32'(imem_req_valid), 32'd1);
    check("drop_req_addr1", imem_req_addr, 32'h2000);
    check("drop_dec_vld1", 32'(dec_valid), 32'd0);
    tick();
    imem_req_ready = 1'b0;
    mid();
    check("drop_dec_vld2", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("drop_dec_vld3", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("drop_dec_vld4", 32'(dec_valid), 32'd1);
    check("drop_dec_pc", dec_pc, 32'h2000);
    check("drop_dec_instr", dec_instr, mem_word(32'h2000));

    // PC wrap, then reset during WAIT with a late response
    tick();
    dec_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    mid();
    check("wrap_redir_pc", pc_next, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    rsp_delay      = 2;
    mid();
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next, 32'h0000_0000);
    tick();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    mid();
    check("wrap_pc_reg", pc, 32'h0000_0000);
    check("rstw_pc_next", pc_next, 32'h100);
    check("rstw_req_vld", 32'(imem_req_valid), 32'd0);
    check("rstw_dec_vld", 32'(dec_valid), 32'd0);
    tick();
    reset = 1'b0;
    mid();
    check("late_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    check("late_dec_vld0", 32'(dec_valid), 32'd0);
    check("late_req_vld", 32'(imem_req_valid), 32'd1);
    check("late_pc_hold", pc_next, 32'h100);
    tick(); mid();
    check("late_dec_vld1", 32'(dec_valid), 32'd0);
    tick(); mid();
    check("late_dec_vld2", 32'(dec_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
